// File: rtl/sci_acc_pkg.sv
// Shared defaults, op packet layout and helpers for the accelerator packet front-end.
package sci_acc_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_NUM_MODES  = 4;
  localparam int unsigned DEF_RES_WIDTH  = 8;
  localparam int unsigned PKT_W          = DEF_DATA_WIDTH + DEF_NUM_MODES + DEF_RES_WIDTH;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_NUM_MODES-1:0]  mode;
    logic [DEF_RES_WIDTH-1:0]  res;
  } op_pkt_t;

  // Exactly one bit set.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/sci_acc_pkt_ingress_if.sv
// Channel-side and core-side bus of the packet ingress block.
interface sci_acc_pkt_ingress_if
  import sci_acc_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_MODES  = DEF_NUM_MODES,
  parameter int unsigned RES_WIDTH  = DEF_RES_WIDTH,
  parameter int unsigned DROP_CNT_W = 8
) ();

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]            pkt_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] op_pkt__data;
  logic [NUM_CH*NUM_MODES-1:0]  op_pkt__mode;
  logic [NUM_CH*RES_WIDTH-1:0]  op_pkt__res;
  logic [NUM_CH-1:0]            ready;
  logic [NUM_CH-1:0]            pkt_dropd;
  logic [NUM_CH*DROP_CNT_W-1:0] drop_cnt;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [NUM_MODES-1:0]         out_mode;
  logic [RES_WIDTH-1:0]         out_res;
  logic [CH_W-1:0]              out_ch;
  logic                         idle;

  modport master (
    output pkt_valid, op_pkt__data, op_pkt__mode, op_pkt__res, out_ready,
    input  ready, pkt_dropd, drop_cnt, out_valid, out_data, out_mode, out_res, out_ch, idle
  );

  modport slave (
    input  pkt_valid, op_pkt__data, op_pkt__mode, op_pkt__res, out_ready,
    output ready, pkt_dropd, drop_cnt, out_valid, out_data, out_mode, out_res, out_ch, idle
  );

endinterface

// File: rtl/sci_acc_pkt_fifo.sv
// Per-channel packet FIFO: pointer-plus-count, registered read data path, no fall-through.
module sci_acc_pkt_fifo
  import sci_acc_pkg::*;
#(
  parameter int unsigned WIDTH = PKT_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/sci_acc_pkt_ingress.sv
// Multi-channel op packet ingress: per-channel FIFOs, drop accounting and a
// round-robin arbiter feeding a single-slot valid/ready output stage.
module sci_acc_pkt_ingress
  import sci_acc_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_MODES  = DEF_NUM_MODES,
  parameter int unsigned RES_WIDTH  = DEF_RES_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DROP_CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  sci_acc_pkt_ingress_if.slave bus
);

  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + NUM_MODES + RES_WIDTH;
  localparam logic [DROP_CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0]            push, pop, full, empty, drop;
  logic [ENTRY_W-1:0]           fifo_dout [NUM_CH];
  logic [NUM_CH-1:0]            dropd_q, dropd_d;
  logic [DROP_CNT_W-1:0]        cnt_q [NUM_CH];
  logic [DROP_CNT_W-1:0]        cnt_d [NUM_CH];
  logic [NUM_CH*DROP_CNT_W-1:0] drop_cnt_flat;
  logic [CH_W-1:0]              rr_q, rr_d, ch_q, ch_d, win;
  logic                         found, load;
  logic                         out_valid_q, out_valid_d;
  logic [ENTRY_W-1:0]           slot_q, slot_d;
  int unsigned                  idx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_WIDTH-1:0] data;
    logic [NUM_MODES-1:0]  mode;
    logic [RES_WIDTH-1:0]  res;
    logic                  mode_ok;

    assign data    = bus.op_pkt__data[i*DATA_WIDTH +: DATA_WIDTH];
    assign mode    = bus.op_pkt__mode[i*NUM_MODES +: NUM_MODES];
    assign res     = bus.op_pkt__res[i*RES_WIDTH +: RES_WIDTH];
    assign mode_ok = is_onehot(32'(mode));
    // ready comes from registered state only: a full FIFO refuses even while popping.
    assign push[i] = bus.pkt_valid[i] && !full[i] && mode_ok;
    assign drop[i] = bus.pkt_valid[i] && (full[i] || !mode_ok);

    sci_acc_pkt_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   ({data, mode, res}),
      .dout  (fifo_dout[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // First non-empty channel at or after rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (32'(rr_q) + k) % NUM_CH;
      if (!found && !empty[CH_W'(idx)]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    load        = found && (!out_valid_q || bus.out_ready);
    pop         = '0;
    rr_d        = rr_q;
    ch_d        = ch_q;
    slot_d      = slot_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    if (load) begin
      pop[win]    = 1'b1;
      out_valid_d = 1'b1;
      slot_d      = fifo_dout[win];
      ch_d        = win;
      rr_d        = (32'(win) == NUM_CH - 1) ? '0 : win + CH_W'(1);
    end
    dropd_d = drop;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = (drop[i] && cnt_q[i] != CNT_MAX) ? cnt_q[i] + DROP_CNT_W'(1) : cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      ch_q        <= '0;
      slot_q      <= '0;
      out_valid_q <= 1'b0;
      dropd_q     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      rr_q        <= rr_d;
      ch_q        <= ch_d;
      slot_q      <= slot_d;
      out_valid_q <= out_valid_d;
      dropd_q     <= dropd_d;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    drop_cnt_flat = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      drop_cnt_flat[i*DROP_CNT_W +: DROP_CNT_W] = cnt_q[i];
    end
  end

  assign bus.ready     = ~full;
  assign bus.pkt_dropd = dropd_q;
  assign bus.drop_cnt  = drop_cnt_flat;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = slot_q[ENTRY_W-1 -: DATA_WIDTH];
  assign bus.out_mode  = slot_q[RES_WIDTH +: NUM_MODES];
  assign bus.out_res   = slot_q[RES_WIDTH-1:0];
  assign bus.out_ch    = ch_q;
  assign bus.idle      = (&empty) && !out_valid_q;

endmodule
